// File: rtl/seg7_pkg.sv
// seg7_pkg: segment codes, invalid-digit code and reader FSM states.
// Segment order is {a,b,c,d,e,f,g}, active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;

  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURED
  } seg7_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational active-low segment pattern -> digit.
// Ports: i_seg_n in, o_digit/o_blank/o_err out. Hex A..F when SEG7_READER_HEX_EN.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg_n,
  output logic [3:0] o_digit,
  output logic       o_blank,
  output logic       o_err
);

  always_comb begin
    o_digit = BCD_INVALID;
    o_blank = 1'b0;
    o_err   = 1'b0;
    unique case (i_seg_n)
      SEG_0:     o_digit = 4'd0;
      SEG_1:     o_digit = 4'd1;
      SEG_2:     o_digit = 4'd2;
      SEG_3:     o_digit = 4'd3;
      SEG_4:     o_digit = 4'd4;
      SEG_5:     o_digit = 4'd5;
      SEG_6:     o_digit = 4'd6;
      SEG_7:     o_digit = 4'd7;
      SEG_8:     o_digit = 4'd8;
      SEG_9:     o_digit = 4'd9;
      SEG_BLANK: o_blank = 1'b1;
`ifdef SEG7_READER_HEX_EN
      SEG_A:     o_digit = 4'hA;
      SEG_B:     o_digit = 4'hB;
      SEG_C:     o_digit = 4'hC;
      SEG_D:     o_digit = 4'hD;
      SEG_E:     o_digit = 4'hE;
      SEG_F:     o_digit = 4'hF;
`endif
      default:   o_err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_frame_reader.sv
// seg7_frame_reader: snoops a muxed active-low 7-seg bus (seg_n, an_n), debounces
// each digit, rebuilds a frame and offers it on frame_valid/frame_ready with
// bcd_out, blank_mask, err_mask and sticky overrun. Hex decode: SEG7_READER_HEX_EN.
module seg7_frame_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic                    frame_ready,
  output logic                    frame_valid,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [NUM_DIGITS-1:0]   err_mask,
  output logic                    overrun
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [6:0]            r_seg_s1, r_seg_s2;
  logic [NUM_DIGITS-1:0] r_an_s1, r_an_s2;

  // Idle bus (all lines high) is the reset value, so no spurious strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
      r_an_s1  <= '1;
      r_an_s2  <= '1;
    end else begin
      r_seg_s1 <= seg_n;
      r_seg_s2 <= r_seg_s1;
      r_an_s1  <= an_n;
      r_an_s2  <= r_an_s1;
    end
  end

  logic [NUM_DIGITS-1:0] w_an;
  logic                  w_onehot;
  logic [IDX_W-1:0]      w_idx;

  assign w_an     = ~r_an_s2;
  assign w_onehot = (w_an != '0) &&
                    ((w_an & (w_an - NUM_DIGITS'(1))) == '0);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_an[i]) w_idx = IDX_W'(i);
    end
  end

  seg7_state_t      r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [6:0]       r_pat, w_pat_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_capture;
  logic             w_same;

  assign w_same = (w_idx == r_idx) && (r_seg_s2 == r_pat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_pat   <= SEG_BLANK;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_pat   <= w_pat_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pat_nxt   = r_pat;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_onehot) begin
          w_state_nxt = SETTLE;
          w_idx_nxt   = w_idx;
          w_pat_nxt   = r_seg_s2;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      SETTLE: begin
        if (!w_onehot) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_same) begin
          // This sample is the STABLE_CYCLES-th identical one.
          if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
            w_capture   = 1'b1;
            w_state_nxt = CAPTURED;
            w_cnt_nxt   = CNT_W'(STABLE_CYCLES);
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_idx_nxt = w_idx;
          w_pat_nxt = r_seg_s2;
          w_cnt_nxt = CNT_W'(1);
        end
      end
      CAPTURED: begin
        if (!w_onehot) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (!w_same) begin
          w_state_nxt = SETTLE;
          w_idx_nxt   = w_idx;
          w_pat_nxt   = r_seg_s2;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  logic [3:0] w_dec_digit;
  logic       w_dec_blank;
  logic       w_dec_err;

  seg7_pattern_decode u_dec (
    .i_seg_n (r_pat),
    .o_digit (w_dec_digit),
    .o_blank (w_dec_blank),
    .o_err   (w_dec_err)
  );

  logic [4*NUM_DIGITS-1:0] r_stage_bcd;
  logic [NUM_DIGITS-1:0]   r_stage_blank;
  logic [NUM_DIGITS-1:0]   r_stage_err;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [NUM_DIGITS-1:0]   w_cap_sel;
  logic                    w_complete;

  always_comb begin
    w_cap_sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_cap_sel[i] = w_capture && (r_idx == IDX_W'(i));
    end
  end

  assign w_complete = &r_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage_bcd   <= '1;
      r_stage_blank <= '0;
      r_stage_err   <= '0;
      r_seen        <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_cap_sel[i]) begin
          r_stage_bcd[4*i +: 4] <= w_dec_digit;
          r_stage_blank[i]      <= w_dec_blank;
          r_stage_err[i]        <= w_dec_err;
        end
      end
      // A completed frame releases seen; a same-cycle capture still counts.
      r_seen <= (w_complete ? '0 : r_seen) | w_cap_sel;
    end
  end

  logic                    r_valid;
  logic [4*NUM_DIGITS-1:0] r_bcd;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic [NUM_DIGITS-1:0]   r_err;
  logic                    r_ovr;
  logic                    w_out_free;
  logic                    w_load;

  assign w_out_free = !r_valid || frame_ready;
  assign w_load     = w_complete && w_out_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_bcd   <= '1;
      r_blank <= '0;
      r_err   <= '0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_bcd   <= r_stage_bcd;
        r_blank <= r_stage_blank;
        r_err   <= r_stage_err;
      end else if (r_valid && frame_ready) begin
        r_valid <= 1'b0;
      end
      if (w_complete && !w_out_free) r_ovr <= 1'b1;
    end
  end

  assign frame_valid = r_valid;
  assign bcd_out     = r_bcd;
  assign blank_mask  = r_blank;
  assign err_mask    = r_err;
  assign overrun     = r_ovr;

endmodule

// File: tb/tb_seg7_frame_reader.sv
// tb_seg7_frame_reader: directed + random scans of a 4-digit display bus,
// checked against a run-length reference model of digit capture and framing.
module tb_seg7_frame_reader;

  localparam int N      = 4;
  localparam int STABLE = 8;

  localparam logic [6:0] P [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100
  };
  localparam logic [6:0] H [6] = '{
    7'b0001000, 7'b1100000, 7'b0110001,
    7'b1000010, 7'b0110000, 7'b0111000
  };

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [6:0]     seg_n = 7'h7F;
  logic [N-1:0]   an_n = '1;
  logic           frame_ready = 1'b0;
  logic           frame_valid;
  logic [4*N-1:0] bcd_out;
  logic [N-1:0]   blank_mask;
  logic [N-1:0]   err_mask;
  logic           overrun;

  always #5 clk = ~clk;

  seg7_frame_reader #(
    .NUM_DIGITS    (N),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .frame_ready (frame_ready),
    .frame_valid (frame_valid),
    .bcd_out     (bcd_out),
    .blank_mask  (blank_mask),
    .err_mask    (err_mask),
    .overrun     (overrun)
  );

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic [3:0]  err;
  } frame_t;

  frame_t obs_q[$];
  frame_t exp_q[$];
  frame_t last_obs;
  frame_t m_slot;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] m_an;
  logic [6:0]   m_seg;
  int           m_run;
  bit           m_done;
  logic [15:0]  m_bcd;
  logic [3:0]   m_blank, m_err, m_seen;
  bit           m_slot_full, m_ovr, m_rdy;

  // Accepted frames: valid and ready both high ahead of the rising edge.
  always @(negedge clk) begin
    if (rst_n && frame_valid && frame_ready) begin
      last_obs = '{bcd_out, blank_mask, err_mask};
      obs_q.push_back(last_obs);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] ref_decode(input logic [6:0] s);
    logic [5:0] r;
    bit hit;
    r = {4'hF, 2'b01};
    hit = 0;
    for (int i = 0; i < 10; i++)
      if (!hit && s == P[i]) begin r = {4'(i), 2'b00}; hit = 1; end
    if (!hit && s == 7'h7F) begin r = {4'hF, 2'b10}; hit = 1; end
`ifdef SEG7_READER_HEX_EN
    for (int i = 0; i < 6; i++)
      if (!hit && s == H[i]) begin r = {4'(10 + i), 2'b00}; hit = 1; end
`endif
    return r;
  endfunction

  function automatic logic [N-1:0] sel(input int i);
    logic [N-1:0] v;
    v = '1;
    v[i] = 1'b0;
    return v;
  endfunction

  function automatic logic [6:0] rand_pat();
    int r;
    r = $urandom_range(0, 19);
    if (r < 10) return P[r];
    if (r < 16) return H[r-10];
    if (r == 16) return 7'h7F;
    return 7'($urandom);
  endfunction

  task automatic model_reset();
    m_an = '1; m_seg = 7'h7F; m_run = 0; m_done = 1;
    m_bcd = '1; m_blank = 0; m_err = 0; m_seen = 0;
    m_slot_full = 0; m_ovr = 0;
  endtask

  task automatic deliver(input frame_t f);
    if (m_rdy) exp_q.push_back(f);
    else if (!m_slot_full) begin m_slot = f; m_slot_full = 1; end
    else m_ovr = 1;
  endtask

  // A digit is captured once per unbroken run of one (one-hot strobe, pattern)
  // value that lasts at least STABLE cycles.
  task automatic model_step(input logic [N-1:0] an, input logic [6:0] seg,
                            input int cyc);
    bit oh;
    int idx;
    logic [5:0] d;
    oh = ($countones(~an) == 1);
    if (oh && an == m_an && seg == m_seg) m_run += cyc;
    else begin
      m_an = an; m_seg = seg; m_run = cyc; m_done = !oh;
    end
    if (!m_done && m_run >= STABLE) begin
      m_done = 1;
      idx = 0;
      for (int i = 0; i < N; i++) if (!an[i]) idx = i;
      d = ref_decode(seg);
      m_bcd[4*idx +: 4] = d[5:2];
      m_blank[idx] = d[1];
      m_err[idx] = d[0];
      m_seen[idx] = 1'b1;
      if (&m_seen) begin
        m_seen = 0;
        deliver('{m_bcd, m_blank, m_err});
      end
    end
  endtask

  task automatic set_ready(input bit v);
    frame_ready = v;
    m_rdy = v;
    if (v && m_slot_full) begin
      exp_q.push_back(m_slot);
      m_slot_full = 0;
    end
  endtask

  task automatic show(input logic [N-1:0] an, input logic [6:0] seg,
                      input int cyc);
    an_n = an;
    seg_n = seg;
    model_step(an, seg, cyc);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cyc);
    show('1, 7'h7F, cyc);
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_nframes"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_bcd"}, obs_q[i].bcd, exp_q[i].bcd);
      chk({tag, "_blank"}, obs_q[i].blank, exp_q[i].blank);
      chk({tag, "_err"}, obs_q[i].err, exp_q[i].err);
    end
    chk({tag, "_overrun"}, overrun, m_ovr);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic scan4(input int d0, input int d1, input int d2, input int d3);
    show(sel(0), P[d0], 20);
    show(sel(1), P[d1], 20);
    show(sel(2), P[d2], 20);
    show(sel(3), P[d3], 20);
  endtask

  initial begin
    model_reset();
    m_rdy = 0;
    last_obs = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", frame_valid, 1'b0);
    chk("rst_bcd", bcd_out, 16'hFFFF);
    chk("rst_blank", blank_mask, 4'h0);
    chk("rst_err", err_mask, 4'h0);
    chk("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    set_ready(1);
    idle(3);

    scan4(1, 2, 3, 4);
    idle(10);
    chk("basic_bcd", last_obs.bcd, 16'h4321);
    chk("basic_masks", {last_obs.blank, last_obs.err}, 8'h00);
    check_frames("basic");

    show(sel(0), P[7], 20);
    show(sel(1), P[8], 20);
    show(sel(2), P[3], 5);
    show(sel(2), P[5], 20);
    show(sel(3), P[9], 20);
    idle(10);
    chk("glitch_d2", last_obs.bcd[11:8], 4'h5);
    check_frames("glitch");

    show(sel(0), 7'b1111111, 20);
    show(sel(1), 7'b1010101, 20);
    show(sel(2), P[0], 20);
    show(sel(3), P[6], 20);
    idle(10);
    chk("be_blank", last_obs.blank, 4'b0001);
    chk("be_err", last_obs.err, 4'b0010);
    chk("be_low_nibbles", last_obs.bcd[7:0], 8'hFF);
    check_frames("blank_err");

    show(sel(0), P[1], 20);
    show(4'b0000, P[8], 6);
    show(sel(1), P[2], 20);
    show(4'b1111, P[3], 4);
    show(4'b0000, P[3], 12);
    show(sel(2), P[3], 20);
    show(4'b1111, P[9], 12);
    show(sel(3), P[4], 20);
    idle(10);
    chk("ghost_bcd", last_obs.bcd, 16'h4321);
    check_frames("ghost");

    set_ready(0);
    scan4(5, 6, 7, 8);
    idle(10);
    chk("bp_valid1", frame_valid, 1'b1);
    chk("bp_first", bcd_out, m_slot.bcd);
    scan4(9, 0, 1, 2);
    idle(10);
    chk("bp_hold", bcd_out, m_slot.bcd);
    chk("bp_hold_valid", frame_valid, 1'b1);
    chk("bp_overrun", overrun, m_ovr);
    set_ready(1);
    @(posedge clk);
    #1;
    chk("bp_valid_drop", frame_valid, 1'b0);
    chk("bp_overrun_sticky", overrun, 1'b1);
    check_frames("backpressure");

    show(sel(0), P[3], 20);
    show(sel(1), P[4], 20);
    an_n = '1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", frame_valid, 1'b0);
    chk("mid_rst_bcd", bcd_out, 16'hFFFF);
    chk("mid_rst_blank", blank_mask, 4'h0);
    chk("mid_rst_err", err_mask, 4'h0);
    chk("mid_rst_overrun", overrun, 1'b0);
    model_reset();
    obs_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    show(sel(2), P[5], 20);
    show(sel(3), P[6], 20);
    idle(10);
    chk("partial_no_valid", frame_valid, 1'b0);
    check_frames("partial");
    scan4(2, 4, 6, 8);
    idle(10);
    check_frames("after_rst");

    for (int f = 0; f < 8; f++) begin
      for (int d = 0; d < N; d++) begin
        if ($urandom_range(0, 3) == 0) begin
          logic [N-1:0] g;
          case ($urandom_range(0, 3))
            0: g = 4'b0000;
            1: g = 4'b1111;
            2: g = 4'b1100;
            default: g = 4'b0101;
          endcase
          show(g, rand_pat(), $urandom_range(1, 12));
        end
        if ($urandom_range(0, 2) == 0)
          show(sel(d), rand_pat(), $urandom_range(1, STABLE - 1));
        show(sel(d), rand_pat(), $urandom_range(STABLE, 20));
      end
      idle($urandom_range(0, 4));
    end
    idle(10);
    check_frames("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_frame_reader.md
Name: seg7_frame_reader

Overview:
- Reverse path of the BCD-to-seven-segment display driver. Snoops a multiplexed, active-low seven-segment display bus (segment lines plus one-hot active-low anode strobes) and decodes each digit back to BCD.
- Assembles one full display frame and hands it out on a valid/ready handshake.
- Used in ATM test benches and on-board self-check to confirm that the displayed balance/PIN digits match internal state.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (anode lines); legal range 1..8.
- STABLE_CYCLES, 8: consecutive identical samples required before a digit is captured; minimum 2.
- CNT_W, $clog2(STABLE_CYCLES+1): settle counter width (derived; do not override).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg_n  in  7  segment lines, active-low; bit6=a, bit5=b … bit0=g.
- an_n  in  NUM_DIGITS  anode strobes, active-low; exactly one low = digit index selected.
- frame_ready  in  1  consumer accepts the frame.
- frame_valid  out  1  a frame is held on the outputs.
- bcd_out  out  4*NUM_DIGITS  digit i in bits [4i+3:4i]; 4'hF for blank/invalid.
- blank_mask  out  NUM_DIGITS  bit i set = digit i was blank (seg_n = 7'b1111111).
- err_mask  out  NUM_DIGITS  bit i set = digit i pattern not decodable.
- overrun  out  1  sticky: a completed frame was dropped.

Behaviour:
- Reset (async, rst_n low): frame_valid=0, bcd_out=all 1s, blank_mask=0, err_mask=0, overrun=0. FSM=IDLE, counter=0, seen mask=0, staging cleared. Reset mid-frame discards any partial frame.
- Inputs are sampled through a 2-flop synchronizer. All cycle counts below are from the synchronized samples (+2 cycles of input latency).
- Decode table (seg_n -> digit):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4
  - 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0001100->9
  - 1111111 -> blank
  - anything else -> error
- FSM states:
  - IDLE: an_n not one-hot-low. On a valid one-hot: latch index and seg pattern, counter=1, go to SETTLE.
  - SETTLE: each cycle with the same index and same pattern, counter+1. A change in pattern or index restarts the count with counter=1 on the new value. If an_n becomes non-one-hot, go to IDLE with counter=0. When the counter reaches STABLE_CYCLES, capture the digit into staging slot [index], set seen[index], and go to CAPTURED.
  - CAPTURED: hold until the index or pattern changes. Then behave as an IDLE->SETTLE entry, or go to IDLE if not one-hot. No recapture of the same digit without a change.
- A capture on an already-seen digit overwrites that slot; the latest value wins.
- Frame completion: the cycle after seen becomes all ones:
  - Output free (frame_valid=0, or frame_valid&frame_ready this cycle): load staging into the outputs, frame_valid=1.
  - Output busy (frame_valid=1, frame_ready=0): the frame is dropped and overrun is set, sticky until reset.
  - In both cases seen is cleared the same cycle.
- Handshake: outputs are stable while frame_valid=1 and frame_ready=0. frame_valid falls the cycle after acceptance unless a new frame loads the same cycle (back-to-back allowed).
- frame_ready is ignored when frame_valid=0.

Optional Feature:
- Macro SEG7_READER_HEX_EN.
- Defined: additionally decode A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000 to 4'hA..4'hF, with no err bit set. Blank still reports 4'hF but is distinguished by blank_mask.
- Undefined: these patterns set err_mask and report 4'hF.

Decomposition:
- Package seg7_pkg holds:
  - localparam segment codes SEG_0..SEG_9, SEG_BLANK, SEG_A..SEG_F;
  - BCD_INVALID=4'hF;
  - FSM state enum (IDLE, SETTLE, CAPTURED).
- One sub-module, seg7_pattern_decode: combinational seg_n -> {digit, blank, err}, with the hex branch under the macro.
- Synchronizer and FSM stay in the top module.

Test Plan:
- Basic frame: scan digits 0..3 with 1,2,3,4 patterns, 20 cycles each, frame_ready=1 -> single frame_valid pulse, bcd_out=16'h4321, blank_mask=0, err_mask=0.
- Glitch rejection: digit 2 shows 0000110 for 5 cycles then 0100100 for 20 cycles -> digit 2 captured as 5, never 3.
- Blank/error: digit 0 = 1111111, digit 1 = 1010101 -> blank_mask=4'b0001, err_mask=4'b0010, both nibbles 4'hF.
- Backpressure/overrun: hold frame_ready=0 across two complete frames -> first frame stays stable, second dropped, overrun=1. Raise frame_ready -> valid drops next cycle, overrun stays 1.
- Ghosting: an_n=4'b0000 and 4'b1111 interleaved with valid scans -> no captures from invalid strobes, frame still completes correctly.
- Reset mid-frame: assert rst_n low after 2 of 4 digits captured -> all outputs at reset values. After release, a fresh 4-digit scan is required before frame_valid.
